// File: rtl/stitch_pipeline_rv.sv
// Ready/valid stitched pipeline: NUM_STAGES increment stages behind an input rank, with bubble collapsing and flush.
// Optional occupancy counter port enabled by defining STITCH_PIPE_OCCUPANCY_EN.
module stitch_pipeline_rv #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 2,
    parameter int INCREMENT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out
`ifdef STITCH_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(NUM_STAGES+2)-1:0] occupancy
`endif
);

    localparam int N = NUM_STAGES;
    localparam logic [DATA_WIDTH-1:0] INC_W = DATA_WIDTH'(INCREMENT);

    logic [DATA_WIDTH-1:0] data_q [0:N];
    logic [N:0]            valid_q;
    logic [N:0]            valid_d;
    logic [N:0]            valid_adv_s;
    logic [N:0]            load_s;
    logic [N+1:0]          accept_s;
    logic                  push_s;

    // Rank k can take an item unless it and every rank downstream is full while the consumer stalls.
    always_comb begin
        logic full_tail;
        full_tail   = 1'b1;
        accept_s    = '0;
        accept_s[N+1] = out_ready;
        for (int k = N; k >= 0; k--) begin
            full_tail   = full_tail & valid_q[k];
            accept_s[k] = out_ready | !full_tail;
        end
    end

    assign input_ready = accept_s[0] & !flush & rst;
    assign push_s      = input_valid & input_ready;

    // Per-rank load enables and next valid bits; flush empties every rank.
    always_comb begin
        load_s         = '0;
        valid_adv_s    = '0;
        load_s[0]      = push_s;
        valid_adv_s[0] = push_s | (valid_q[0] & !accept_s[1]);
        for (int k = 1; k <= N; k++) begin
            load_s[k]      = valid_q[k-1] & accept_s[k];
            valid_adv_s[k] = load_s[k] | (valid_q[k] & !accept_s[k+1]);
        end
        if (flush) begin
            valid_d = '0;
        end else begin
            valid_d = valid_adv_s;
        end
    end

    // Valid chain with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload ranks: unreset, load only from a valid upstream rank.
    always_ff @(posedge clk) begin
        if (load_s[0]) begin
            data_q[0] <= x;
        end
        for (int k = 1; k <= N; k++) begin
            if (load_s[k]) begin
                data_q[k] <= data_q[k-1] + INC_W;
            end
        end
    end

    assign out       = data_q[N];
    assign out_valid = valid_q[N];

`ifdef STITCH_PIPE_OCCUPANCY_EN
    localparam int OW = $clog2(NUM_STAGES+2);

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic          pop_s;

    assign pop_s = valid_q[N] & out_ready;

    // Item count follows handshakes; tracks the popcount of the valid chain.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (push_s && !pop_s) begin
            occ_d = occ_q + OW'(1);
        end else if (!push_s && pop_s) begin
            occ_d = occ_q - OW'(1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
